pmcontroller: RTL and testbench

- Instruction-sequencing control unit that drives the control side of the 3-register + accumulator datapath (register write selects, clock enables, B-operand select, ALU opcode, carry-in).
- Accepts 12-bit instructions over a valid/ready handshake, decodes them, and sequences single- or two-cycle execution.
- Reports retired-instruction count, halt and illegal-instruction status.
- Sits between the instruction source (testbench or ROM sequencer) and the datapath control inputs.

---
 rtl/pmcontroller.sv | 113 +++++++++++
 tb/tb_pmcontroller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pmcontroller.sv
// Instruction-sequencing control unit: accepts 12-bit instructions over valid/ready,
// decodes them and drives datapath controls for one- or two-cycle execution.
module pmcontroller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [11:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [2:0]       w,
  output logic [3:0]       ce,
  output logic [1:0]       sel,
  output logic [2:0]       s,
  output logic             cin,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {StFetch, StExec, StWb, StHalt} state_e;

  state_e           state_q, state_d;
  logic [11:0]      ir_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] op;
  logic [1:0] rd, rs;
  logic [2:0] rd_oh;
  logic       illegal;
  logic       retire;

  assign op = ir_q[11:8];
  assign rd = ir_q[3:2];
  assign rs = ir_q[1:0];

  // rd=3 names no register; the all-zero decode keeps every enable low.
  assign rd_oh   = (rd == 2'd3) ? 3'b000 : (3'b001 << rd);
  assign illegal = (op > 4'd5) ||
                   ((rd == 2'd3) && ((op == 4'd1) || (op == 4'd2) || (op == 4'd4)));

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    w           = 3'b000;
    ce          = 4'b0000;
    sel         = 2'd3;
    s           = 3'd0;
    cin         = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        retire  = 1'b1;
        if (!illegal) begin
          case (op)
            4'd1: ce = {1'b0, rd_oh};
            4'd2: begin
              ce = {1'b0, rd_oh};
              w  = rd_oh;
            end
            4'd3, 4'd4: begin
              sel = rs;
              s   = ir_q[7:5];
              cin = ir_q[4];
              ce  = 4'b1000;
              // ALUST retires only after its write-back cycle.
              if (op == 4'd4) begin
                state_d = StWb;
                retire  = 1'b0;
              end
            end
            4'd5:    state_d = StHalt;
            default: ;
          endcase
        end
      end
      StWb: begin
        w       = rd_oh;
        ce      = {1'b0, rd_oh};
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StFetch;
      ir_q    <= 12'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StFetch) && instr_valid) ir_q <= instr;
      if ((state_q == StExec) && illegal) err_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign busy      = (state_q == StExec) || (state_q == StWb);
  assign halted    = (state_q == StHalt);
  assign err       = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_pmcontroller.sv
// Self-checking bench for pmcontroller: directed scenarios plus random instruction
// streams compared against a per-instruction behavioural model.
module tb_pmcontroller;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic [11:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    w;
  logic [3:0]    ce;
  logic [1:0]    sel;
  logic [2:0]    s;
  logic          cin;
  logic          busy;
  logic          halted;
  logic          err;
  logic [CW-1:0] instr_cnt;

  pmcontroller #(.CNT_W(CW)) dut (
    .clk        (clk),
    .clr        (clr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .w          (w),
    .ce         (ce),
    .sel        (sel),
    .s          (s),
    .cin        (cin),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;
  bit exp_err = 0;
  bit exp_halt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Idle-state controls expected whenever no instruction is executing.
  task automatic check_idle(input string tag);
    check_eq({tag, ".ce"}, 32'(ce), 0);
    check_eq({tag, ".w"}, 32'(w), 0);
    check_eq({tag, ".sel"}, 32'(sel), 3);
    check_eq({tag, ".s"}, 32'(s), 0);
    check_eq({tag, ".cin"}, 32'(cin), 0);
    check_eq({tag, ".busy"}, 32'(busy), 0);
    check_eq({tag, ".cnt"}, 32'(instr_cnt), 32'(exp_cnt));
    check_eq({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    exp_cnt = 0;
    exp_err = 0;
    exp_halt = 0;
    check_eq("rst.ready", 32'(instr_ready), 1);
    check_eq("rst.halted", 32'(halted), 0);
    check_idle("rst");
  endtask

  // Called at a negedge in FETCH; returns at a negedge back in FETCH (or in HALT).
  task automatic run_instr(input logic [11:0] ins, input bit hold_valid);
    int op, rd, rs;
    bit bad;
    int e_ce, e_w, e_sel, e_s, e_cin;
    op = int'(ins[11:8]);
    rd = int'(ins[3:2]);
    rs = int'(ins[1:0]);
    bad = (op > 5) || (rd == 3 && (op == 1 || op == 2 || op == 4));
    e_ce = 0; e_w = 0; e_sel = 3; e_s = 0; e_cin = 0;
    if (!bad) begin
      if (op == 1) e_ce = 1 << rd;
      if (op == 2) begin e_ce = 1 << rd; e_w = 1 << rd; end
      if (op == 3 || op == 4) begin
        e_sel = rs; e_s = int'(ins[7:5]); e_cin = int'(ins[4]); e_ce = 8;
      end
    end
    check_eq("fetch.ready", 32'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    // Source keeps valid up with junk while busy; the controller must ignore it.
    if (hold_valid) instr = 12'($urandom);
    else instr_valid = 1'b0;
    check_eq("exec.ce", 32'(ce), 32'(e_ce));
    check_eq("exec.w", 32'(w), 32'(e_w));
    check_eq("exec.sel", 32'(sel), 32'(e_sel));
    check_eq("exec.s", 32'(s), 32'(e_s));
    check_eq("exec.cin", 32'(cin), 32'(e_cin));
    check_eq("exec.busy", 32'(busy), 1);
    check_eq("exec.ready", 32'(instr_ready), 0);
    check_eq("exec.cnt", 32'(instr_cnt), 32'(exp_cnt));
    @(negedge clk);
    if (op == 4 && !bad) begin
      check_eq("wb.ce", 32'(ce), 32'(1 << rd));
      check_eq("wb.w", 32'(w), 32'(1 << rd));
      check_eq("wb.sel", 32'(sel), 3);
      check_eq("wb.s", 32'(s), 0);
      check_eq("wb.cin", 32'(cin), 0);
      check_eq("wb.busy", 32'(busy), 1);
      check_eq("wb.cnt", 32'(instr_cnt), 32'(exp_cnt));
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    if (bad) exp_err = 1;
    instr_valid = 1'b0;
    if (op == 5 && !bad) begin
      exp_halt = 1;
      for (int i = 0; i < 4; i++) begin
        instr = 12'h104;
        instr_valid = 1'b1;
        check_eq("halt.halted", 32'(halted), 1);
        check_eq("halt.ready", 32'(instr_ready), 0);
        check_eq("halt.ce", 32'(ce), 0);
        check_eq("halt.busy", 32'(busy), 0);
        check_eq("halt.cnt", 32'(instr_cnt), 32'(exp_cnt));
        @(negedge clk);
      end
      instr_valid = 1'b0;
    end else begin
      check_eq("ret.ready", 32'(instr_ready), 1);
      check_eq("ret.halted", 32'(halted), 0);
      check_idle("ret");
    end
  endtask

  initial begin
    clr = 1'b1;
    instr = 12'd0;
    instr_valid = 1'b0;
    do_reset();

    // Directed scenarios.
    run_instr(12'h104, 1'b1);
    run_instr(12'h352, 1'b0);
    run_instr(12'h408, 1'b1);
    run_instr(12'hA00, 1'b0);
    check_eq("err.after_illegal", 32'(err), 1);
    run_instr(12'h20C, 1'b0);
    run_instr(12'h104, 1'b0);
    check_eq("err.sticky", 32'(err), 1);
    run_instr(12'h500, 1'b1);
    do_reset();
    check_eq("halt.cleared_cnt", 32'(instr_cnt), 0);

    // clr during write-back: ALUST must not retire.
    check_eq("wbclr.ready", 32'(instr_ready), 1);
    instr = 12'h408;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("wbclr.in_wb", 32'(ce), 32'h4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("wbclr.ce", 32'(ce), 0);
    check_eq("wbclr.ready", 32'(instr_ready), 1);
    check_eq("wbclr.busy", 32'(busy), 0);
    check_eq("wbclr.cnt", 32'(instr_cnt), 0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CW); i++) run_instr(12'h000, i[0]);
    check_eq("wrap.cnt", 32'(instr_cnt), 0);

    // Random stream; reset whenever a HALT lands.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run_instr(12'($urandom), 1'($urandom));
      if (exp_halt) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
